wb_arbiter: RTL and testbench

- Parametrised N-channel writeback/commit arbiter. It generalises the single exu/mem writeback mux and the exe2wb stage.
- Each execution channel (exu, mem, muldiv, ...) pushes completed instructions into a private buffer.
- The arbiter retires one instruction per cycle into a registered writeback/commit stage, which drives the regfile write port and the difftest commit signals.
- Adds per-channel backpressure, selectable fixed or round-robin priority, flush, and a retired-instruction counter.

---
 rtl/wb_arbiter_pkg.sv | 27 ++
 rtl/wb_arbiter_fifo.sv | 60 ++++++
 rtl/wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback/commit arbiter.
// An entry carries everything the commit stage needs for one retired instruction.
package wb_arbiter_pkg;

  localparam int LREG_W     = 5;
  localparam int WB_DATA_W  = 64;
  localparam int WB_PC_W    = 64;
  localparam int WB_INSTR_W = 32;

  localparam logic [63:0] MMIO_BASE = 64'h0000_0000_4000_0000;
  localparam logic [63:0] MMIO_SIZE = 64'h0000_0000_4000_0000;

  typedef struct packed {
    logic [LREG_W-1:0]     rd;
    logic                  need_to_wb;
    logic                  is_load;
    logic                  mmio;
    logic [WB_DATA_W-1:0]  result;
    logic [WB_PC_W-1:0]    pc;
    logic [WB_INSTR_W-1:0] instr;
  } wb_entry_t;

  function automatic logic in_mmio(input logic [63:0] addr);
    return (addr >= MMIO_BASE) && (addr < MMIO_BASE + MMIO_SIZE);
  endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Per-channel DEPTH-entry FIFO of writeback entries with synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  wb_entry_t   mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is never reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/wb_arbiter.sv
// N-channel writeback/commit arbiter: per-channel buffers, fixed or round-robin
// selection, a registered commit stage and a retired-instruction counter.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 2,
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int RR_MODE = 1,
  localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [NUM_CH-1:0]           ch_valid,
  output logic [NUM_CH-1:0]           ch_ready,
  input  logic [NUM_CH*LREG_W-1:0]    ch_rd,
  input  logic [NUM_CH-1:0]           ch_need_to_wb,
  input  logic [NUM_CH-1:0]           ch_is_load,
  input  logic [NUM_CH-1:0]           ch_mmio,
  input  logic [NUM_CH*DATA_W-1:0]    ch_result,
  input  logic [NUM_CH*PC_W-1:0]      ch_pc,
  input  logic [NUM_CH*INSTR_W-1:0]   ch_instr,
  output logic                        regfile_write_valid,
  output logic [LREG_W-1:0]           regfile_write_rd,
  output logic [DATA_W-1:0]           regfile_write_data,
  output logic                        commit_valid,
  output logic                        commit_skip,
  output logic                        commit_rfwen,
  output logic [PC_W-1:0]             commit_pc,
  output logic [INSTR_W-1:0]          commit_instr,
  output logic [63:0]                 commit_cnt,
  output logic [GW-1:0]               grant_ch
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] pop;
  wb_entry_t         heads [NUM_CH];

  logic              granted;
  logic [GW-1:0]     win;
  wb_entry_t         sel;

  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [63:0]       cnt_q, cnt_d;
  logic              commit_valid_q, rfwen_q, skip_q;
  logic [LREG_W-1:0] rd_q;
  logic [DATA_W-1:0] data_q;
  logic [PC_W-1:0]   pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic [GW-1:0]     grant_q;

  assign ch_ready = ~full;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wb_entry_t in_entry;

    always_comb begin
      in_entry            = '0;
      in_entry.rd         = ch_rd[LREG_W*i +: LREG_W];
      in_entry.need_to_wb = ch_need_to_wb[i];
      in_entry.is_load    = ch_is_load[i];
      in_entry.mmio       = ch_mmio[i];
      in_entry.result     = WB_DATA_W'(ch_result[DATA_W*i +: DATA_W]);
      in_entry.pc         = WB_PC_W'(ch_pc[PC_W*i +: PC_W]);
      in_entry.instr      = WB_INSTR_W'(ch_instr[INSTR_W*i +: INSTR_W]);
    end

    assign pop[i] = granted && (int'(win) == i);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (flush),
      .push_i  (ch_valid[i]),
      .pop_i   (pop[i]),
      .data_i  (in_entry),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (heads[i])
    );
  end

  // Scan starts at rr_ptr in round-robin mode, at channel 0 otherwise.
  always_comb begin
    int idx;
    idx     = 0;
    granted = 1'b0;
    win     = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      idx = (RR_MODE != 0) ? ((int'(rr_ptr_q) + off) % NUM_CH) : off;
      if (!granted && !empty[idx]) begin
        granted = 1'b1;
        win     = GW'(idx);
      end
    end
  end

  assign sel = heads[win];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (granted && !flush) begin
      rr_ptr_d = GW'((int'(win) + 1) % NUM_CH);
      cnt_d    = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      commit_valid_q <= 1'b0;
      rfwen_q        <= 1'b0;
      skip_q         <= 1'b0;
      rd_q           <= '0;
      data_q         <= '0;
      pc_q           <= '0;
      instr_q        <= '0;
      grant_q        <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      if (flush) begin
        commit_valid_q <= 1'b0;
        rfwen_q        <= 1'b0;
        skip_q         <= 1'b0;
      end else begin
        commit_valid_q <= granted;
        rfwen_q        <= granted & sel.need_to_wb & ~(sel.mmio & sel.is_load);
        skip_q         <= granted & sel.mmio;
        if (granted) begin
          rd_q    <= sel.rd;
          data_q  <= DATA_W'(sel.result);
          pc_q    <= PC_W'(sel.pc);
          instr_q <= INSTR_W'(sel.instr);
          grant_q <= win;
        end
      end
    end
  end

  assign commit_valid        = commit_valid_q;
  assign regfile_write_valid = rfwen_q;
  assign commit_rfwen        = rfwen_q;
  assign commit_skip         = skip_q;
  assign regfile_write_rd    = rd_q;
  assign regfile_write_data  = data_q;
  assign commit_pc           = pc_q;
  assign commit_instr        = instr_q;
  assign commit_cnt          = cnt_q;
  assign grant_ch            = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: one round-robin and one fixed-priority instance
// share the producer stimulus; each scenario checks the instance it targets.
module tb_wb_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [1:0]   ch_valid, ch_need, ch_load, ch_mmio;
  logic [9:0]   ch_rd;
  logic [127:0] ch_result, ch_pc;
  logic [63:0]  ch_instr;

  logic [1:0]  rr_ready, fx_ready;
  logic        rr_rfv, rr_cv, rr_skip, rr_crfwen, fx_rfv, fx_cv, fx_skip, fx_crfwen;
  logic [4:0]  rr_rd, fx_rd;
  logic [63:0] rr_data, rr_pc, rr_cnt, fx_data, fx_pc, fx_cnt;
  logic [31:0] rr_instr, fx_instr;
  logic [0:0]  rr_grant, fx_grant;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_v = 8'b0111_1110;
  logic [7:0]  exp_g = 8'b0111_0000;
  logic [63:0] exp_d [8] = '{64'h0, 64'h400, 64'h401, 64'h402, 64'h500, 64'h501, 64'h502, 64'h0};

  always #5 clock = ~clock;

  wb_arbiter #(.NUM_CH(2), .DEPTH(2), .RR_MODE(1)) u_rr (
    .clock(clock), .reset(reset), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(rr_ready), .ch_rd(ch_rd),
    .ch_need_to_wb(ch_need), .ch_is_load(ch_load), .ch_mmio(ch_mmio),
    .ch_result(ch_result), .ch_pc(ch_pc), .ch_instr(ch_instr),
    .regfile_write_valid(rr_rfv), .regfile_write_rd(rr_rd), .regfile_write_data(rr_data),
    .commit_valid(rr_cv), .commit_skip(rr_skip), .commit_rfwen(rr_crfwen),
    .commit_pc(rr_pc), .commit_instr(rr_instr), .commit_cnt(rr_cnt), .grant_ch(rr_grant)
  );

  wb_arbiter #(.NUM_CH(2), .DEPTH(2), .RR_MODE(0)) u_fx (
    .clock(clock), .reset(reset), .flush(flush),
    .ch_valid(ch_valid), .ch_ready(fx_ready), .ch_rd(ch_rd),
    .ch_need_to_wb(ch_need), .ch_is_load(ch_load), .ch_mmio(ch_mmio),
    .ch_result(ch_result), .ch_pc(ch_pc), .ch_instr(ch_instr),
    .regfile_write_valid(fx_rfv), .regfile_write_rd(fx_rd), .regfile_write_data(fx_data),
    .commit_valid(fx_cv), .commit_skip(fx_skip), .commit_rfwen(fx_crfwen),
    .commit_pc(fx_pc), .commit_instr(fx_instr), .commit_cnt(fx_cnt), .grant_ch(fx_grant)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [4:0] rd, input logic [63:0] data,
                        input logic [63:0] pc, input logic nw, input logic ld, input logic mm);
    ch_valid[c]          = 1'b1;
    ch_rd[5*c +: 5]      = rd;
    ch_result[64*c +: 64] = data;
    ch_pc[64*c +: 64]    = pc;
    ch_instr[32*c +: 32] = data[31:0] + 32'h13;
    ch_need[c]           = nw;
    ch_load[c]           = ld;
    ch_mmio[c]           = mm;
  endtask

  task automatic clr(input int c);
    ch_valid[c] = 1'b0;
  endtask

  task automatic do_reset();
    ch_valid = '0;
    reset    = 1'b1;
    #10;
    reset    = 1'b0;
  endtask

  initial begin
    int i0, i1;
    logic [1:0] r;
    reset = 1'b1; flush = 1'b0;
    ch_valid = '0; ch_need = '0; ch_load = '0; ch_mmio = '0;
    ch_rd = '0; ch_result = '0; ch_pc = '0; ch_instr = '0;

    repeat (2) @(posedge clock);
    #3;
    check("rst_valid", rr_cv, 0);
    check("rst_ready", rr_ready, 2'b11);
    check("rst_cnt", rr_cnt, 0);
    check("rst_rfwen", rr_rfv, 0);
    reset = 1'b0;

    // basic commit
    set_ch(0, 5'd3, 64'h55, 64'h8000_0000, 1'b1, 1'b0, 1'b0);
    tick();
    clr(0);
    check("basic_latency", rr_cv, 0);
    tick();
    check("basic_valid", rr_cv, 1);
    check("basic_rfv", rr_rfv, 1);
    check("basic_crfwen", rr_crfwen, 1);
    check("basic_rd", rr_rd, 3);
    check("basic_data", rr_data, 64'h55);
    check("basic_pc", rr_pc, 64'h8000_0000);
    check("basic_instr", rr_instr, 32'h68);
    check("basic_cnt", rr_cnt, 1);
    check("basic_grant", rr_grant, 0);
    tick();
    check("basic_idle", rr_cv, 0);

    // round-robin
    do_reset();
    set_ch(0, 5'd10, 64'h100, 64'h1000, 1'b1, 1'b0, 1'b0);
    set_ch(1, 5'd11, 64'h200, 64'h2000, 1'b1, 1'b0, 1'b0);
    tick();
    set_ch(0, 5'd10, 64'h101, 64'h1004, 1'b1, 1'b0, 1'b0);
    set_ch(1, 5'd11, 64'h201, 64'h2004, 1'b1, 1'b0, 1'b0);
    tick();
    clr(0); clr(1);
    for (int i = 0; i < 4; i++) begin
      check("rr_valid", rr_cv, 1);
      check("rr_grant", rr_grant, i % 2);
      check("rr_data", rr_data, ((i % 2) ? 64'h200 : 64'h100) + 64'(i / 2));
      tick();
    end
    check("rr_drained", rr_cv, 0);
    check("rr_cnt", rr_cnt, 4);

    // fixed priority with backpressure
    do_reset();
    i0 = 0; i1 = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (i0 < 3) set_ch(0, 5'd5, 64'h400 + 64'(i0), 64'h4000, 1'b1, 1'b0, 1'b0);
      else clr(0);
      if (i1 < 3) set_ch(1, 5'd6, 64'h500 + 64'(i1), 64'h5000, 1'b1, 1'b0, 1'b0);
      else clr(1);
      r = fx_ready;
      tick();
      if (ch_valid[0] && r[0]) i0++;
      if (ch_valid[1] && r[1]) i1++;
      check("fx_valid", fx_cv, exp_v[cyc]);
      if (exp_v[cyc]) begin
        check("fx_grant", fx_grant, exp_g[cyc]);
        check("fx_data", fx_data, exp_d[cyc]);
        check("fx_rd", fx_rd, exp_g[cyc] ? 5'd6 : 5'd5);
      end
      if (cyc == 1 || cyc == 3) check("fx_ch1_ready_low", fx_ready[1], 0);
      if (cyc == 4) check("fx_ch1_ready_back", fx_ready[1], 1);
    end
    clr(0); clr(1);
    check("fx_cnt", fx_cnt, 6);

    // mmio load / store / plain load on ch1
    set_ch(1, 5'd7, 64'h77, 64'h3000, 1'b1, 1'b1, 1'b1);
    tick(); clr(1); tick();
    check("mmio_ld_valid", rr_cv, 1);
    check("mmio_ld_skip", rr_skip, 1);
    check("mmio_ld_rfv", rr_rfv, 0);
    check("mmio_ld_crfwen", rr_crfwen, 0);
    set_ch(1, 5'd0, 64'h78, 64'h3004, 1'b0, 1'b0, 1'b1);
    tick(); clr(1); tick();
    check("mmio_st_valid", rr_cv, 1);
    check("mmio_st_skip", rr_skip, 1);
    check("mmio_st_rfv", rr_rfv, 0);
    set_ch(1, 5'd8, 64'h88, 64'h3008, 1'b1, 1'b1, 1'b0);
    tick(); clr(1); tick();
    check("ld_skip", rr_skip, 0);
    check("ld_rfv", rr_rfv, 1);
    check("ld_rd", rr_rd, 8);

    // flush
    do_reset();
    set_ch(0, 5'd1, 64'h600, 64'h6000, 1'b1, 1'b0, 1'b0);
    set_ch(1, 5'd2, 64'h700, 64'h7000, 1'b1, 1'b0, 1'b0);
    tick();
    set_ch(0, 5'd1, 64'h601, 64'h6004, 1'b1, 1'b0, 1'b0);
    set_ch(1, 5'd2, 64'h701, 64'h7004, 1'b1, 1'b0, 1'b0);
    tick();
    check("pre_flush_data", rr_data, 64'h600);
    check("pre_flush_cnt", rr_cnt, 1);
    clr(1);
    set_ch(0, 5'd1, 64'h602, 64'h6008, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clr(0);
    check("flush_ready", rr_ready, 2'b11);
    check("flush_ready_fx", fx_ready, 2'b11);
    check("flush_valid", rr_cv, 0);
    check("flush_cnt", rr_cnt, 1);
    tick();
    check("flush_dropped", rr_cv, 0);
    set_ch(1, 5'd9, 64'h900, 64'h9000, 1'b1, 1'b0, 1'b0);
    tick(); clr(1); tick();
    check("post_flush_valid", rr_cv, 1);
    check("post_flush_data", rr_data, 64'h900);
    check("post_flush_grant", rr_grant, 1);
    check("post_flush_cnt", rr_cnt, 2);

    // asynchronous reset between edges
    set_ch(0, 5'd4, 64'ha0, 64'ha000, 1'b1, 1'b0, 1'b0);
    set_ch(1, 5'd4, 64'hb0, 64'hb000, 1'b1, 1'b0, 1'b1);
    tick(); tick();
    check("pre_arst_valid", rr_cv, 1);
    #2;
    reset = 1'b1;
    ch_valid = '0;
    #1;
    check("arst_valid", rr_cv, 0);
    check("arst_ready", rr_ready, 2'b11);
    check("arst_cnt", rr_cnt, 0);
    check("arst_data", rr_data, 0);
    check("arst_rfv", rr_rfv, 0);
    check("arst_fx_ready", fx_ready, 2'b11);
    check("arst_fx_valid", fx_cv, 0);
    check("arst_fx_outs", {fx_rfv, fx_skip, fx_crfwen, fx_rd, fx_grant}, 0);
    check("arst_fx_pc", fx_pc, 0);
    check("arst_fx_instr", fx_instr, 0);
    check("arst_fx_data", fx_data, 0);
    check("arst_fx_cnt", fx_cnt, 0);
    #2;
    reset = 1'b0;
    set_ch(0, 5'd12, 64'ha5, 64'hc000, 1'b1, 1'b0, 1'b0);
    tick(); clr(0); tick();
    check("post_arst_valid", rr_cv, 1);
    check("post_arst_data", rr_data, 64'ha5);
    check("post_arst_cnt", rr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
